mem_stage_lsu: RTL and testbench

//  Load/store unit of the MEM stage, between the EX/MEM and MEM/WB segmented registers.
//  - Takes the ALU result as the address, plus store data and control from EX/MEM.
//  - Runs a req/gnt/rvalid transaction on the data-memory bus.
//  - Aligns and sign-/zero-extends load data, which feeds data_memory_out_in of MEM/WB.
//  - Stalls the pipeline while a bus transaction is in flight.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/mem_stage_lsu.sv | 122 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// The optional trap build is selected with LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Access size; any unlisted funct3 code behaves as a word access.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // Byte lane actually used: offending low bits are dropped for half/word.
    function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned_acc(input logic [2:0] f3, input logic [1:0] a);
        case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load path: picks the addressed lane(s) out of the raw
// bus word and sign- or zero-extends them to the full datapath width.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Extend the selected lane(s) according to the access size/sign.
    always_comb begin
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid bus transaction per
// memory instruction and stalls the front of the pipeline meanwhile.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus traffic, misaligned pulse) instead of ignoring the low bits.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int data_bits = 32,
    parameter int addr_bits = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [2:0]           funct3,
    input  logic [addr_bits-1:0] addr,
    input  logic [data_bits-1:0] store_data,
    output logic                 stall,
    output logic                 result_valid,
    output logic [data_bits-1:0] load_data,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [addr_bits-1:0] bus_addr,
    output logic [data_bits-1:0] bus_wdata,
    output logic [3:0]           bus_wstrb,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [data_bits-1:0] bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                 misaligned
`endif
);

    lsu_state_t           state, state_nx;
    logic [addr_bits-1:0] addr_q;
    logic [2:0]           f3_q;
    logic [data_bits-1:0] sdata_q;
    logic                 we_q;
    logic [1:0]           off_q;
    logic                 accept;
    logic                 mis_now;
    logic [3:0]           strb;
    logic [data_bits-1:0] aligned;

    assign accept = (state == IDLE) && ex_valid && (mem_read || mem_write);
    assign off_q  = eff_offset(f3_q, addr_q[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign mis_now    = misaligned_acc(funct3, addr[1:0]);
    assign misaligned = (state == DONE) && mis_q;
`else
    assign mis_now = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata  (bus_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (aligned)
    );

    // Next-state logic; a trapped access skips the bus entirely.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = mis_now ? DONE : REQ;
            REQ:  if (bus_gnt) state_nx = we_q ? DONE : WAIT;
            WAIT: if (bus_rvalid) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, request latch and load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            f3_q      <= '0;
            sdata_q   <= '0;
            we_q      <= 1'b0;
            load_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= addr;
                f3_q    <= funct3;
                sdata_q <= store_data;
                we_q    <= mem_write && !mem_read;   // read+write counts as a load
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q   <= mis_now;
                if (mis_now) load_data <= '0;
`endif
            end
            if (state == WAIT && bus_rvalid) load_data <= aligned;
        end
    end

    // Byte-lane enables for stores.
    always_comb begin
        case (f3_size(f3_q))
            SZ_B:    strb = 4'b0001 << off_q;
            SZ_H:    strb = 4'b0011 << off_q;
            default: strb = 4'b1111;
        endcase
    end

    assign stall        = accept || (state == REQ) || (state == WAIT);
    assign result_valid = (state == DONE);
    assign bus_req      = (state == REQ);
    assign bus_we       = bus_req && we_q;
    assign bus_addr     = bus_req ? {addr_q[addr_bits-1:2], 2'b00} : '0;
    assign bus_wdata    = bus_we ? (sdata_q << {off_q, 3'b000}) : '0;
    assign bus_wstrb    = bus_we ? strb : 4'b0000;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu with a transaction-level
// reference model. Follows LSU_MISALIGN_TRAP_EN if defined.
module tb_mem_stage_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, result_valid;
    logic [31:0] load_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        mis_out;

    int errs   = 0;
    int checks = 0;
    logic [31:0] last_load;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .result_valid (result_valid),
        .load_data    (load_data),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misaligned   (mis_out)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign mis_out = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---- reference model: access rules expressed in bytes ----
    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        int lo = int'(a % 4);
        if (n == 1) return lo;
        if (n == 2) return (lo / 2) * 2;
        return 0;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return (n > 1) && (a % n != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] raw);
        int n = nbytes(f3);
        logic [31:0] v = raw >> (8 * lane_of(f3, a));
        if (n == 1) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
        end else if (n == 2) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        return ((32'd1 << nbytes(f3)) - 1) << lane_of(f3, a);
    endfunction

    // One memory instruction from EX/MEM acceptance to the cycle after DONE.
    task automatic run_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int gdly, input int rdly, input logic [31:0] raw);
        bit is_ld = rd;
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        check({tag, ".acc_stall"}, 32'(stall), 32'd1);
        check({tag, ".acc_req"}, 32'(bus_req), 32'd0);
        if (TRAP && is_mis(f3, a)) begin
            last_load = 32'd0;
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i <= gdly; i++) begin
                @(posedge clk); #1;
                bus_gnt    = (i == gdly);
                bus_rvalid = 1'($urandom_range(0, 1));   // must be ignored in REQ
                bus_rdata  = $urandom;
                @(negedge clk);
                check({tag, ".req"}, 32'(bus_req), 32'd1);
                check({tag, ".req_stall"}, 32'(stall), 32'd1);
                check({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
                check({tag, ".we"}, 32'(bus_we), 32'(!is_ld));
                check({tag, ".wdata"}, bus_wdata, is_ld ? 32'd0 : sd << (8 * lane_of(f3, a)));
                check({tag, ".wstrb"}, 32'(bus_wstrb), is_ld ? 32'd0 : model_strb(f3, a));
                check({tag, ".req_rv"}, 32'(result_valid), 32'd0);
            end
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (is_ld) begin
                for (int j = 0; j <= rdly; j++) begin
                    bus_rvalid = (j == rdly);
                    bus_rdata  = (j == rdly) ? raw : $urandom;
                    @(negedge clk);
                    check({tag, ".wait_stall"}, 32'(stall), 32'd1);
                    check({tag, ".wait_req"}, 32'(bus_req), 32'd0);
                    @(posedge clk); #1;
                    bus_rvalid = 1'b0;
                end
                last_load = model_load(f3, a, raw);
            end
        end
        @(negedge clk);
        check({tag, ".done_rv"}, 32'(result_valid), 32'd1);
        check({tag, ".done_stall"}, 32'(stall), 32'd0);
        check({tag, ".done_req"}, 32'(bus_req), 32'd0);
        check({tag, ".load_data"}, load_data, last_load);
        check({tag, ".mis"}, 32'(mis_out), 32'(TRAP && is_mis(f3, a)));
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check({tag, ".idle_rv"}, 32'(result_valid), 32'd0);
        check({tag, ".idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        last_load = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.req", 32'(bus_req), 32'd0);
        check("rst.rv", 32'(result_valid), 32'd0);
        check("rst.load_data", load_data, 32'd0);
        check("rst.wstrb", 32'(bus_wstrb), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // directed cases
        run_op("lw", 1, 0, 3'd2, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF);
        check("lw.const", load_data, 32'hDEADBEEF);
        run_op("lb", 1, 0, 3'd0, 32'h103, 32'd0, 0, 1, 32'h80FF_FF00);
        check("lb.const", load_data, 32'hFFFFFF80);
        run_op("lbu", 1, 0, 3'd4, 32'h103, 32'd0, 1, 0, 32'h80FF_FF00);
        check("lbu.const", load_data, 32'h00000080);
        run_op("sh", 0, 1, 3'd1, 32'h102, 32'h0000ABCD, 0, 0, 32'd0);
        run_op("gnt4", 0, 1, 3'd2, 32'h2000, 32'h12345678, 4, 0, 32'd0);
        run_op("lw_mis", 1, 0, 3'd2, 32'h101, 32'd0, 0, 0, 32'hCAFEF00D);

        // reset while waiting for read data
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'd2; addr = 32'h40;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        check("rstw.in_wait", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = 32'd0;
        @(negedge clk);
        check("rstw.stall", 32'(stall), 32'd0);
        check("rstw.req", 32'(bus_req), 32'd0);
        check("rstw.load_data", load_data, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstw.late_rv", 32'(result_valid), 32'd0);
            check("rstw.late_ld", load_data, 32'd0);
        end

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            int kind = int'($urandom_range(0, 2));
            logic [2:0] f3;
            bit rd = (kind != 1);
            bit wr = (kind != 0);
            if (rd) f3 = 3'($urandom_range(0, 7));
            else    f3 = 3'($urandom_range(0, 2));
            run_op("rnd", rd, wr, f3, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
